// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Purpose : shared encodings for the fetch sequencer and the next-PC unit.
//           Branch classes, next-PC select codes, FSM states, error codes,
//           default reset PC / timeout, and the branch-to-select mapping.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        BR_SEQ = 3'b000,
        BR_J   = 3'b001,
        BR_BEQ = 3'b010,
        BR_BNE = 3'b011,
        BR_JR  = 3'b100
    } br_type_e;

    // Must stay in lock-step with the next-PC unit's mux encoding.
    typedef enum logic [2:0] {
        NPC_PC4    = 3'b000,
        NPC_JUMP   = 3'b001,
        NPC_BRANCH = 3'b011,
        NPC_REG    = 3'b100
    } npc_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_EXEC = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_TIMEOUT  = 2'b01,
        ERR_MISALIGN = 2'b10
    } err_code_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam int          DEFAULT_MAX_WAIT = 15;

    // Unlisted branch classes (101..111) fall through to sequential fetch.
    function automatic npc_op_e select_npc_op(input logic [2:0] br, input logic eq);
        npc_op_e op;
        op = NPC_PC4;
        case (br)
            BR_J:    op = NPC_JUMP;
            BR_BEQ:  op = eq ? NPC_BRANCH : NPC_PC4;
            BR_BNE:  op = eq ? NPC_PC4 : NPC_BRANCH;
            BR_JR:   op = NPC_REG;
            default: op = NPC_PC4;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Purpose : bundles the datapath, next-PC unit and instruction-memory signals
//           seen by the fetch sequencer.
// Signals : br_type/cmp_eq/stall from the datapath, npc from the next-PC unit,
//           im_ack from instruction memory; pc, npc_op, im_req, instr_valid,
//           fetch_err, err_code, instr_count driven by the sequencer.
// Modports: master = environment side, slave = fetch_sequencer.
// -----------------------------------------------------------------------------
interface fetch_sequencer_if;
    logic [2:0]  br_type;
    logic        cmp_eq;
    logic        stall;
    logic [31:0] npc;
    logic        im_ack;
    logic [31:0] pc;
    logic [2:0]  npc_op;
    logic        im_req;
    logic        instr_valid;
    logic        fetch_err;
    logic [1:0]  err_code;
    logic [31:0] instr_count;

    modport master (
        output br_type, cmp_eq, stall, npc, im_ack,
        input  pc, npc_op, im_req, instr_valid, fetch_err, err_code, instr_count
    );

    modport slave (
        input  br_type, cmp_eq, stall, npc, im_ack,
        output pc, npc_op, im_req, instr_valid, fetch_err, err_code, instr_count
    );
endinterface

// File: rtl/fetch_timer.sv
// -----------------------------------------------------------------------------
// fetch_timer
// Purpose : 8-bit wait counter for the instruction-memory request phase.
// Ports   : i_clk, i_reset (sync, active high), i_clr (zero the count),
//           i_en (count this cycle), o_timeout (pulse in the cycle the count
//           would reach MAX_WAIT).
// -----------------------------------------------------------------------------
module fetch_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);
    localparam logic [7:0] LAST_COUNT = 8'(MAX_WAIT - 1);

    logic [7:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_count <= 8'd0;
        end else if (i_en) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Flags the MAX_WAIT-th waiting cycle itself, so the FSM can leave on
    // that edge; an ack in that same cycle still wins in the FSM.
    assign o_timeout = i_en && (r_count == LAST_COUNT);

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Purpose : owns the architectural PC, sequences instruction fetch with a
//           req/ack handshake, selects the next-PC source, flags timeout and
//           misaligned targets, counts retired instructions.
// Ports   : i_clk, i_reset (sync, active high), bus (fetch_sequencer_if.slave).
//
// state | meaning
// IDLE  | one cycle after reset before the first request
// REQ   | im_req high, waiting for im_ack (bounded by MAX_WAIT)
// EXEC  | instruction valid; advance PC when not stalled
// ERR   | sticky error, nothing issued until reset
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    fetch_sequencer_if.slave   bus
);
    state_e      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr_count;
    logic        r_im_req;
    logic        r_instr_valid;
    logic        r_fetch_err;
    err_code_e   r_err_code;

    logic w_in_req;
    logic w_timer_en;
    logic w_timer_clr;
    logic w_timeout;
    logic w_npc_aligned;

    assign w_in_req      = (r_state == ST_REQ);
    assign w_timer_en    = w_in_req && !bus.im_ack;
    assign w_timer_clr   = !w_in_req || bus.im_ack;
    assign w_npc_aligned = (bus.npc[1:0] == 2'b00);

    fetch_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clr     (w_timer_clr),
        .i_en      (w_timer_en),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= RESET_PC;
            r_instr_count <= 32'd0;
            r_im_req      <= 1'b0;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            r_err_code    <= ERR_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state  <= ST_REQ;
                    r_im_req <= 1'b1;
                end
                ST_REQ: begin
                    if (bus.im_ack) begin
                        r_state       <= ST_EXEC;
                        r_im_req      <= 1'b0;
                        r_instr_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_state     <= ST_ERR;
                        r_im_req    <= 1'b0;
                        r_fetch_err <= 1'b1;
                        r_err_code  <= ERR_TIMEOUT;
                    end
                end
                ST_EXEC: begin
                    // A stall masks the alignment check until it drops.
                    if (!bus.stall) begin
                        r_instr_valid <= 1'b0;
                        if (w_npc_aligned) begin
                            r_pc          <= bus.npc;
                            r_instr_count <= r_instr_count + 32'd1;
                            r_state       <= ST_REQ;
                            r_im_req      <= 1'b1;
                        end else begin
                            r_state     <= ST_ERR;
                            r_fetch_err <= 1'b1;
                            r_err_code  <= ERR_MISALIGN;
                        end
                    end
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.npc_op      = (r_state == ST_EXEC) ? select_npc_op(bus.br_type, bus.cmp_eq)
                                                  : NPC_PC4;
    assign bus.pc          = r_pc;
    assign bus.im_req      = r_im_req;
    assign bus.instr_valid = r_instr_valid;
    assign bus.fetch_err   = r_fetch_err;
    assign bus.err_code    = r_err_code;
    assign bus.instr_count = r_instr_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  op;
        logic [31:0] cnt;
    } exp_t;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .RESET_PC (RST_PC),
        .MAX_WAIT (15)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference select rule taken straight from the branch-class table.
    function automatic logic [2:0] ref_op(input logic [2:0] br, input logic eq);
        if (br == 3'b001) return 3'b001;
        if (br == 3'b100) return 3'b100;
        if (br == 3'b010 && eq) return 3'b011;
        if (br == 3'b011 && !eq) return 3'b011;
        return 3'b000;
    endfunction

    // Behaves as the next-PC unit would for the model's current PC.
    function automatic logic [31:0] ref_npc(input logic [2:0] op);
        logic [31:0] r;
        logic [31:0] off;
        r = $urandom();
        off = {{14{r[15]}}, r[15:0], 2'b00};
        case (op)
            3'b001:  return {m_pc[31:28], r[25:0], 2'b00};
            3'b011:  return m_pc + 32'd4 + off;
            3'b100:  return {r[31:2], 2'b00};
            default: return m_pc + 32'd4;
        endcase
    endfunction

    task automatic model_reset();
        m_pc  = RST_PC;
        m_cnt = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch/execute: wait for the request, ack after ack_d idle cycles,
    // then hold stall for stall_n EXEC cycles before letting it retire.
    task automatic do_instr(input logic [2:0] br, input logic eq, input logic [31:0] nx,
                            input int stall_n, input int ack_d);
        exp_t e;
        int   k;
        k = 0;
        while (!bus.im_req && k < 40) begin
            tick();
            k++;
        end
        chk("wait_im_req", 32'(bus.im_req), 32'd1);
        bus.im_ack = 1'b0;
        repeat (ack_d) tick();
        bus.br_type = br;
        bus.cmp_eq  = eq;
        bus.npc     = nx;
        bus.stall   = (stall_n > 0);
        bus.im_ack  = 1'b1;
        e.pc  = m_pc;
        e.op  = ref_op(br, eq);
        e.cnt = m_cnt;
        repeat (stall_n + 1) sb.push_back(e);
        tick();
        for (int s = 0; s < stall_n; s++) begin
            bus.im_ack = 1'($urandom_range(0, 1));
            chk("no_err_in_stall", 32'(bus.fetch_err), 32'd0);
            tick();
        end
        bus.im_ack = 1'b0;
        bus.stall  = 1'b0;
        tick();
        if (nx[1:0] == 2'b00) begin
            m_pc  = nx;
            m_cnt = m_cnt + 32'd1;
        end
    endtask

    // Scoreboard monitor: one expected entry per cycle the instruction is valid.
    always @(negedge clk) begin
        if (bus.instr_valid) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_valid", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("exec_pc", bus.pc, e.pc);
                chk("exec_npc_op", 32'(bus.npc_op), 32'(e.op));
                chk("exec_instr_count", bus.instr_count, e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  br;
        logic        eq;
        logic [31:0] tgt;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.br_type = 3'b000;
        bus.cmp_eq  = 1'b0;
        bus.stall   = 1'b0;
        bus.npc     = 32'd0;
        bus.im_ack  = 1'b0;
        model_reset();

        repeat (2) tick();
        chk("rst_pc", bus.pc, RST_PC);
        chk("rst_im_req", 32'(bus.im_req), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_err", 32'(bus.fetch_err), 32'd0);
        chk("rst_err_code", 32'(bus.err_code), 32'd0);
        chk("rst_count", bus.instr_count, 32'd0);
        chk("rst_npc_op", 32'(bus.npc_op), 32'd0);
        rst = 1'b0;
        chk("idle_im_req", 32'(bus.im_req), 32'd0);
        tick();
        chk("req_im_req", 32'(bus.im_req), 32'd1);

        // Sequential fetch, back-to-back acks.
        for (int i = 0; i < 3; i++) do_instr(3'b000, 1'b0, m_pc + 32'd4, 0, 0);
        chk("seq_count3", bus.instr_count, 32'd3);
        chk("seq_pc", bus.pc, 32'h0000_300C);

        // Stall for 4 EXEC cycles, then retire to 0x3010.
        do_instr(3'b000, 1'b0, m_pc + 32'd4, 4, 0);
        chk("stall_pc", bus.pc, 32'h0000_3010);
        chk("stall_count", bus.instr_count, 32'd4);

        // Branch-class select codes.
        do_instr(3'b010, 1'b1, ref_npc(3'b011), 0, 1);
        do_instr(3'b010, 1'b0, ref_npc(3'b000), 0, 0);
        do_instr(3'b011, 1'b1, ref_npc(3'b000), 0, 2);
        do_instr(3'b011, 1'b0, ref_npc(3'b011), 0, 0);
        do_instr(3'b100, 1'b0, ref_npc(3'b100), 1, 0);
        do_instr(3'b001, 1'b1, ref_npc(3'b001), 0, 0);
        do_instr(3'b110, 1'b1, ref_npc(3'b000), 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            br  = 3'($urandom_range(0, 7));
            eq  = 1'($urandom_range(0, 1));
            tgt = ref_npc(ref_op(br, eq));
            do_instr(br, eq, tgt, int'($urandom_range(0, 3)), int'($urandom_range(0, 14)));
        end
        chk("rand_count", bus.instr_count, m_cnt);
        chk("rand_pc", bus.pc, m_pc);

        // Timeout: 15 REQ cycles without ack.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        bus.im_ack = 1'b0;
        repeat (15) tick();
        chk("to_wait_req", 32'(bus.im_req), 32'd1);
        chk("to_wait_err", 32'(bus.fetch_err), 32'd0);
        tick();
        chk("to_err", 32'(bus.fetch_err), 32'd1);
        chk("to_code", 32'(bus.err_code), 32'd1);
        chk("to_im_req", 32'(bus.im_req), 32'd0);
        chk("to_valid", 32'(bus.instr_valid), 32'd0);
        bus.im_ack = 1'b1;
        repeat (3) tick();
        bus.im_ack = 1'b0;
        chk("err_sticky", 32'(bus.fetch_err), 32'd1);
        chk("err_sticky_valid", 32'(bus.instr_valid), 32'd0);

        // Reset from ERR, then a normal fetch.
        rst = 1'b1;
        tick();
        chk("rst_err_pc", bus.pc, RST_PC);
        chk("rst_err_flag", 32'(bus.fetch_err), 32'd0);
        chk("rst_err_code", 32'(bus.err_code), 32'd0);
        chk("rst_err_req", 32'(bus.im_req), 32'd0);
        rst = 1'b0;
        model_reset();
        do_instr(3'b000, 1'b0, m_pc + 32'd4, 0, 0);

        // Ack arriving in the 15th waiting cycle wins over the timeout.
        do_instr(3'b000, 1'b0, m_pc + 32'd4, 0, 14);
        chk("ack15_no_err", 32'(bus.fetch_err), 32'd0);
        chk("ack15_count", bus.instr_count, 32'd2);

        // Reset in the middle of a request.
        bus.im_ack = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_pc", bus.pc, RST_PC);
        chk("rst_mid_req", 32'(bus.im_req), 32'd0);
        chk("rst_mid_count", bus.instr_count, 32'd0);
        rst = 1'b0;
        model_reset();
        tick();
        chk("rst_mid_req_again", 32'(bus.im_req), 32'd1);
        do_instr(3'b000, 1'b0, m_pc + 32'd4, 0, 0);

        // Misaligned jr target, masked by a 2-cycle stall first.
        do_instr(3'b100, 1'b0, 32'h0000_3002, 2, 0);
        chk("mis_err", 32'(bus.fetch_err), 32'd1);
        chk("mis_code", 32'(bus.err_code), 32'd2);
        chk("mis_pc_hold", bus.pc, m_pc);
        chk("mis_count_hold", bus.instr_count, m_cnt);
        chk("mis_im_req", 32'(bus.im_req), 32'd0);
        chk("mis_valid", 32'(bus.instr_valid), 32'd0);

        repeat (2) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction fetch for the MIPS core and owns the architectural PC register.
- Drives the select code of the next-PC unit and accepts the computed next PC back from it.
- Runs a request/acknowledge handshake with instruction memory and holds the PC on hazard stalls.
- Detects memory timeout and misaligned targets, and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- MAX_WAIT, 15, cycles to wait for im_ack before declaring a timeout (range 1..255).

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- br_type  in  3  branch class of the instruction in EXEC: 000 seq, 001 j/jal, 010 beq, 011 bne, 100 jr/jalr. Codes 101..111 are treated as seq.
- cmp_eq  in  1  rs==rt comparison result, valid in EXEC.
- stall  in  1  hazard stall from the datapath.
- npc  in  32  next PC computed by the next-PC unit from pc and npc_op.
- im_ack  in  1  instruction memory data valid.
- pc  out  32  current PC; drives IM address and the next-PC unit.
- npc_op  out  3  next-PC select: 000 PC+4, 001 jump target, 011 PC+4+offset, 100 register.
- im_req  out  1  fetch request.
- instr_valid  out  1  fetched instruction is present and executing.
- fetch_err  out  1  sticky error flag.
- err_code  out  2  01 timeout, 10 misaligned target, 00 none.
- instr_count  out  32  retired instruction count.

Behaviour:
- Reset values (synchronous, so they apply at the first clock edge with reset=1): state=IDLE, pc=RESET_PC, im_req=0, instr_valid=0, npc_op=000, fetch_err=0, err_code=00, instr_count=0, wait counter=0.
- Reset dominates all other inputs in every state, including mid-request; im_req drops at the next edge.
- States:
  - IDLE: one cycle, then REQ.
  - REQ: im_req=1 (registered). Wait counter increments each cycle without im_ack. On im_ack go to EXEC and clear the counter. If the counter reaches MAX_WAIT without im_ack, go to ERR with err_code=01.
  - EXEC: instr_valid=1. npc_op is combinational from br_type and cmp_eq:
    - seq → 000; j → 001; jr → 100.
    - beq → 011 if cmp_eq=1, else 000.
    - bne → 011 if cmp_eq=0, else 000.
  - EXEC with stall=1: pc holds, state stays EXEC, instr_count holds.
  - EXEC with stall=0 and npc[1:0]==00: pc<=npc, instr_count+=1 (wraps at 2^32), go to REQ.
  - EXEC with stall=0 and npc[1:0]!=00: pc holds, err_code=10, go to ERR.
  - ERR: im_req=0, instr_valid=0, fetch_err=1. Terminal until reset.
- Outside EXEC, npc_op=000 and instr_valid=0.
- Minimum fetch latency is one REQ cycle plus one EXEC cycle, i.e. one instruction per 2 cycles at best.
- Simultaneous events:
  - im_ack in the same cycle the counter reaches MAX_WAIT: ack wins, no error.
  - Stall asserted in EXEC with a misaligned npc: stall wins, no error until stall drops.
- im_ack outside REQ is ignored.
- pc[1:0] is always 00 because only RESET_PC (required aligned) and aligned npc are ever loaded.

Decomposition:
- Shared package (header include):
  - br_type codes.
  - npc_op codes; these must match the next-PC unit encoding.
  - state encodings IDLE/REQ/EXEC/ERR.
  - err_code values.
  - default RESET_PC.
- One sub-module, fetch_timer:
  - 8-bit wait counter with clear/enable.
  - Outputs a timeout pulse at MAX_WAIT.

Test Plan:
- Reset, then im_ack held 1 with br_type=000 and npc=pc+4:
  - pc sequence 0x3000, 0x3004, 0x3008.
  - instr_valid on alternate cycles.
  - instr_count=3 after 3 EXEC exits.
- EXEC with br_type=010, cmp_eq=1 → npc_op=011. Repeat with cmp_eq=0 → npc_op=000. bne gives the inverse. jr → 100; j → 001.
- stall=1 for 4 EXEC cycles:
  - pc and instr_count frozen; instr_valid stays 1.
  - On stall=0, pc loads npc=0x3010.
- im_ack withheld for 15 REQ cycles → fetch_err=1, err_code=01, im_req=0. im_ack arriving at cycle 15 → no error.
- jr with npc=0x3002 → err_code=10, pc stays at the jr address. With stall=1 simultaneously → no error until stall deasserts.
- reset asserted mid-REQ and during ERR → next edge gives pc=0x3000, fetch_err=0, state IDLE, then a normal fetch.
